// File: rtl/comb_vector_checker.sv
// Self-test sweeper for Y = NAND(NAND(A,B), AND(C,~B,D), NOR(E,F)): drives all 64 vectors,
// waits SETTLE_CYCLES per vector, samples Y against a golden model and reports mismatches.
module comb_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [5:0]       o_vec_out,
  input  logic             i_dut_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [5:0]       o_first_fail_vec,
  output logic             o_first_fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [5:0]       r_vec;
  logic [5:0]       w_vec_nxt;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_nxt;
  logic [5:0]       r_ffv;
  logic [5:0]       w_ffv_nxt;
  logic             r_ffval;
  logic             w_ffval_nxt;
  logic             r_pass;

  logic w_t1;
  logic w_t2;
  logic w_t3;
  logic w_gold;
  logic w_mismatch;

  assign w_t1   = ~(r_vec[5] & r_vec[4]);
  assign w_t2   = r_vec[3] & ~r_vec[4] & r_vec[2];
  assign w_t3   = ~(r_vec[1] | r_vec[0]);
  assign w_gold = ~(w_t1 & w_t2 & w_t3);
  // Case inequality so an undriven or X response from the unit under test is a failure.
  assign w_mismatch = (i_dut_y !== w_gold);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_ffv_nxt   = r_ffv;
    w_ffval_nxt = r_ffval;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
          w_vec_nxt   = '0;
          w_err_nxt   = '0;
          w_ffv_nxt   = '0;
          w_ffval_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          if (w_mismatch) begin
            if (!(&r_err)) begin
              w_err_nxt = r_err + ERR_W'(1);
            end
            if (!r_ffval) begin
              w_ffv_nxt   = r_vec;
              w_ffval_nxt = 1'b1;
            end
          end
          if (r_vec == 6'd63) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_vec_nxt   = r_vec + 6'd1;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_ffv   <= '0;
      r_ffval <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_ffv   <= w_ffv_nxt;
      r_ffval <= w_ffval_nxt;
      // Registered alongside the DONE transition so pass is valid in the first done cycle.
      r_pass  <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
    end
  end

  assign o_vec_out          = r_vec;
  assign o_busy             = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign o_done             = (r_state == ST_DONE);
  assign o_pass             = r_pass;
  assign o_err_count        = r_err;
  assign o_first_fail_vec   = r_ffv;
  assign o_first_fail_valid = r_ffval;

endmodule

// File: tb/tb_comb_vector_checker.sv
// Bench: two checker instances (settle 4 / 7-bit count, settle 2 / 4-bit count) against modelled networks.
module tb_comb_vector_checker;

  localparam int SA  = 4;
  localparam int SB  = 2;
  localparam int EWA = 7;
  localparam int EWB = 4;

  localparam int M_IDEAL = 0;
  localparam int M_ST1   = 1;
  localparam int M_ST0   = 2;
  localparam int M_RAND  = 3;
  localparam int M_DLY   = 4;

  typedef struct {
    bit pass;
    int err;
    int ffv;
    bit ffval;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic [5:0] vec_a, vec_b, ffv_a, ffv_b;
  logic y_a, y_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffval_a, ffval_b;
  logic [EWA-1:0] err_a;
  logic [EWB-1:0] err_b;
  logic [2:0] pipe_a = '0;
  logic [2:0] pipe_b = '0;

  int mode = M_IDEAL;
  logic [63:0] fmask = '0;
  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];

  comb_vector_checker #(.SETTLE_CYCLES(SA), .ERR_W(EWA)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_vec_out(vec_a), .i_dut_y(y_a), .o_busy(busy_a), .o_done(done_a),
    .o_pass(pass_a), .o_err_count(err_a), .o_first_fail_vec(ffv_a),
    .o_first_fail_valid(ffval_a));

  comb_vector_checker #(.SETTLE_CYCLES(SB), .ERR_W(EWB)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_vec_out(vec_b), .i_dut_y(y_b), .o_busy(busy_b), .o_done(done_b),
    .o_pass(pass_b), .o_err_count(err_b), .o_first_fail_vec(ffv_b),
    .o_first_fail_valid(ffval_b));

  function automatic bit gold_f(logic [5:0] v);
    bit a, b, c, d, e, f;
    {a, b, c, d, e, f} = v;
    return !(!(a && b) && (c && !b && d) && !(e || f));
  endfunction

  function automatic bit comb_y(int m, logic [5:0] v, logic [63:0] msk);
    case (m)
      M_ST1:   return 1'b1;
      M_ST0:   return 1'b0;
      M_RAND:  return gold_f(v) ^ msk[v];
      default: return gold_f(v);
    endcase
  endfunction

  // Reference: what a full sweep must report, given the network behaviour and settle time.
  function automatic exp_t model(int m, int s, int errmax, logic [63:0] msk);
    exp_t e;
    int n;
    n = 0;
    e.ffv = 0;
    e.ffval = 1'b0;
    for (int v = 0; v < 64; v++) begin
      bit g, o;
      g = gold_f(6'(v));
      if (m == M_DLY) o = (s >= 3) ? g : gold_f(6'((v == 0) ? 0 : v - 1));
      else            o = comb_y(m, 6'(v), msk);
      if (o != g) begin
        n++;
        if (!e.ffval) begin
          e.ffval = 1'b1;
          e.ffv = v;
        end
      end
    end
    e.err = (n > errmax) ? errmax : n;
    e.pass = (n == 0);
    return e;
  endfunction

  // Network under test with a three-register output delay.
  always @(posedge clk) begin
    pipe_a <= {pipe_a[1:0], gold_f(vec_a)};
    pipe_b <= {pipe_b[1:0], gold_f(vec_b)};
  end

  always_comb begin
    y_a = (mode == M_DLY) ? pipe_a[2] : comb_y(mode, vec_a, fmask);
    y_b = (mode == M_DLY) ? pipe_b[2] : comb_y(mode, vec_b, fmask);
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares results whenever a checker enters DONE.
  initial begin
    bit pa, pb;
    exp_t e;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (done_a && !pa) begin
        if (qa.size() == 0) fail_now("unexpected_done_a");
        else begin
          e = qa.pop_front();
          check("pass_a", pass_a, e.pass);
          check("err_a", err_a, e.err);
          check("ffv_a", ffv_a, e.ffv);
          check("ffval_a", ffval_a, e.ffval);
        end
      end
      if (done_b && !pb) begin
        if (qb.size() == 0) fail_now("unexpected_done_b");
        else begin
          e = qb.pop_front();
          check("pass_b", pass_b, e.pass);
          check("err_b", err_b, e.err);
          check("ffv_b", ffv_b, e.ffv);
          check("ffval_b", ffval_b, e.ffval);
        end
      end
      pa = done_a;
      pb = done_b;
    end
  end

  task automatic check_reset_vals(string tag);
    check({tag, "_vec_a"}, vec_a, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_pass_a"}, pass_a, 0);
    check({tag, "_err_a"}, err_a, 0);
    check({tag, "_ffv_a"}, ffv_a, 0);
    check({tag, "_ffval_a"}, ffval_a, 0);
    check({tag, "_vec_b"}, vec_b, 0);
    check({tag, "_err_b"}, err_b, 0);
    check({tag, "_ffval_b"}, ffval_b, 0);
  endtask

  task automatic sweep(int m, int pulse_at);
    int n, busyc, hold36, vp;
    mode = m;
    qa.push_back(model(m, SA, (1 << EWA) - 1, fmask));
    qb.push_back(model(m, SB, (1 << EWB) - 1, fmask));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_vec_a", vec_a, 0);
    check("first_busy_a", busy_a, 1);
    check("first_vec_b", vec_b, 0);
    n = 0;
    busyc = 0;
    hold36 = 0;
    vp = 0;
    while (!done_a && n < 2000) begin
      if (busy_a) busyc++;
      if (vec_a == 6'd36) hold36++;
      start = (n == pulse_at);
      if (n == pulse_at) vp = vec_a;
      tick();
      n++;
      if (pulse_at >= 0 && n == pulse_at + 1)
        check("start_ignored", int'(vec_a >= 6'(vp) && vec_a != 0 && busy_a), 1);
    end
    start = 1'b0;
    if (n >= 2000) fail_now("sweep_timeout");
    check("busy_cycles", busyc, 64 * (SA + 1));
    check("done_latency", n, 64 * (SA + 1));
    check("hold_vec36", hold36, SA + 1);
    check("done_vec_a", vec_a, 63);
    tick();
    tick();
    check("done_held_a", done_a, 1);
  endtask

  task automatic wait_vec_a(int target);
    int n;
    n = 0;
    while (vec_a != 6'(target) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) fail_now("wait_vec_timeout");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_vals("reset");
    tick();
    check("idle_busy_a", busy_a, 0);

    sweep(M_IDEAL, -1);
    sweep(M_ST1, 40);
    sweep(M_ST0, -1);
    sweep(M_DLY, -1);

    // Reset mid-sweep, with errors already accumulated.
    mode = M_ST0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec_a(20);
    check("pre_rst_ffval_a", ffval_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midrst");
    check("midrst_busy_b", busy_b, 0);
    sweep(M_IDEAL, -1);

    // Abort at vector 30: partial results kept, back to idle.
    mode = M_ST1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec_a(30);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_vec_a", vec_a, 0);
    check("abort_busy_a", busy_a, 0);
    check("abort_done_a", done_a, 0);
    check("abort_err_a", err_a, 1);
    check("abort_ffv_a", ffv_a, 12);
    check("abort_ffval_a", ffval_a, 1);
    check("abort_vec_b", vec_b, 0);
    check("abort_busy_b", busy_b, 0);
    check("abort_err_b", err_b, 2);
    tick();
    tick();
    tick();
    check("abort_idle_busy_a", busy_a, 0);
    check("abort_idle_done_a", done_a, 0);

    for (int r = 0; r < 4; r++) begin
      fmask = {$urandom, $urandom};
      if (r % 2 == 1) fmask = fmask & {$urandom, $urandom} & {$urandom, $urandom};
      sweep(M_RAND, int'($urandom_range(150, 10)));
    end

    tick();
    tick();
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "global timeout");
  end

endmodule
